// File: rtl/stretched_pulse_tx_arbiter.sv
// -----------------------------------------------------------------------------
// stretched_pulse_tx_arbiter
//
// Source-domain scheduler for a shared stretched-pulse CDC channel. It collects
// single-cycle event pulses from NREQ requesters into a pending register and
// grants them one at a time in round-robin order. For each grant it drives
// tx_pulse high for exactly STRETCH cycles, with tx_id held alongside. It then
// holds tx_pulse low for a guard gap, so the receive-side synchroniser and edge
// detector see every pulse as a separate event.
//
// Ports
//   wr_clk     in   1     source-domain clock
//   wr_resetn  in   1     asynchronous active-low reset
//   req_pulse  in   NREQ  single-cycle event per requester
//   clr_err    in   1     synchronous clear of drop_err
//   tx_pulse   out  1     registered stretched pulse to the CDC line
//   tx_id      out  ID_W  registered index of the granted requester
//   ack        out  NREQ  one-cycle pulse on the granted bit in its last high cycle
//   pending    out  NREQ  requests accepted but not yet granted
//   busy       out  1     high whenever the FSM is not in IDLE
//   drop_err   out  NREQ  sticky: an event merged into an already pending bit
// -----------------------------------------------------------------------------
module stretched_pulse_tx_arbiter #(
    parameter int NREQ    = 4,
    parameter int ID_W    = 2,
    parameter int STRETCH = 4,
    parameter int GAP     = 4
) (
    input  logic            wr_clk,
    input  logic            wr_resetn,
    input  logic [NREQ-1:0] req_pulse,
    input  logic            clr_err,
    output logic            tx_pulse,
    output logic [ID_W-1:0] tx_id,
    output logic [NREQ-1:0] ack,
    output logic [NREQ-1:0] pending,
    output logic            busy,
    output logic [NREQ-1:0] drop_err
);

    // The counter only ever holds STRETCH-1 or GAP-1 and counts down to zero.
    localparam int CNT_MAX = (STRETCH > GAP) ? STRETCH : GAP;
    localparam int CNT_W   = (CNT_MAX <= 2) ? 1 : $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] CNT_STRETCH = CNT_W'(STRETCH - 1);
    localparam logic [CNT_W-1:0] CNT_GAP     = CNT_W'(GAP - 1);
    localparam logic [ID_W-1:0]  ID_LAST     = ID_W'(NREQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    state_t            state_q,    state_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;
    logic [ID_W-1:0]   rr_ptr_q,   rr_ptr_d;
    logic [NREQ-1:0]   pending_q,  pending_d;
    logic [NREQ-1:0]   drop_err_q, drop_err_d;
    logic              tx_pulse_q, tx_pulse_d;
    logic [ID_W-1:0]   tx_id_q,    tx_id_d;
    logic [NREQ-1:0]   ack_q,      ack_d;
    logic              busy_q,     busy_d;

    // -------------------------------------------------------------------------
    // Round-robin search: rotate pending so that bit rr_ptr lands at bit 0,
    // take the lowest set bit, then rotate its offset back into an index.
    // -------------------------------------------------------------------------
    logic [2*NREQ-1:0] pend_dbl;
    logic              grant_found;
    logic [ID_W-1:0]   grant_id;
    logic              grant_fire;
    logic [NREQ-1:0]   grant_oh;

    always_comb begin
        int sum;
        pend_dbl    = {pending_q, pending_q} >> rr_ptr_q;
        grant_found = 1'b0;
        grant_id    = '0;
        sum         = 0;
        for (int off = 0; off < NREQ; off++) begin
            if (!grant_found && pend_dbl[off]) begin
                grant_found = 1'b1;
                sum         = int'(rr_ptr_q) + off;
                if (sum >= NREQ) begin
                    sum = sum - NREQ;
                end
                grant_id = ID_W'(sum);
            end
        end
    end

    // One-hot of the bit being granted this cycle (all zero when no grant).
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_grant_oh
        assign grant_oh[gi] = grant_fire && (grant_id == ID_W'(gi));
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge wr_clk or negedge wr_resetn) begin
        if (!wr_resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        grant_fire = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_found) begin
                    grant_fire = 1'b1;
                    state_d    = ST_SEND;
                    cnt_d      = CNT_STRETCH;
                end
            end
            ST_SEND: begin
                if (cnt_q == '0) begin
                    state_d = ST_GAP;
                    cnt_d   = CNT_GAP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs, registered from the next state so that tx_pulse, busy and
    // ack come straight off flops and cannot glitch on the CDC line.
    // ack lands in the cycle the registered counter reads zero in SEND.
    // -------------------------------------------------------------------------
    always_comb begin
        tx_pulse_d = (state_d == ST_SEND);
        busy_d     = (state_d != ST_IDLE);
        tx_id_d    = grant_fire ? grant_id : tx_id_q;
        ack_d      = '0;
        for (int i = 0; i < NREQ; i++) begin
            if ((state_d == ST_SEND) && (cnt_d == '0) && (tx_id_d == ID_W'(i))) begin
                ack_d[i] = 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Pending / drop_err / round-robin pointer
    // -------------------------------------------------------------------------
    always_comb begin
        // A new event wins over the grant-clear on the same bit, so it stays
        // pending for a later transfer instead of being lost.
        pending_d  = (pending_q & ~grant_oh) | req_pulse;
        // A merge only counts as a drop when the bit is still waiting; the bit
        // being granted this cycle is re-armed instead.
        drop_err_d = (clr_err ? '0 : drop_err_q) | (req_pulse & pending_q & ~grant_oh);
        rr_ptr_d   = rr_ptr_q;
        if (grant_fire) begin
            rr_ptr_d = (grant_id == ID_LAST) ? '0 : grant_id + ID_W'(1);
        end
    end

    always_ff @(posedge wr_clk or negedge wr_resetn) begin
        if (!wr_resetn) begin
            pending_q  <= '0;
            drop_err_q <= '0;
            rr_ptr_q   <= '0;
            tx_pulse_q <= 1'b0;
            tx_id_q    <= '0;
            ack_q      <= '0;
            busy_q     <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            drop_err_q <= drop_err_d;
            rr_ptr_q   <= rr_ptr_d;
            tx_pulse_q <= tx_pulse_d;
            tx_id_q    <= tx_id_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
        end
    end

    assign tx_pulse = tx_pulse_q;
    assign tx_id    = tx_id_q;
    assign ack      = ack_q;
    assign pending  = pending_q;
    assign busy     = busy_q;
    assign drop_err = drop_err_q;

endmodule

// File: tb/tb_stretched_pulse_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_stretched_pulse_tx_arbiter
//
// Directed bench for stretched_pulse_tx_arbiter (NREQ=4, ID_W=2, STRETCH=4,
// GAP=4). Inputs change 1 time unit after a rising edge; outputs are read at
// the same point. "c" counts edges after the one that samples the first
// request (c=0). A grant in IDLE therefore gives tx_pulse high for c=1..4,
// ack at c=4, GAP for c=5..8, IDLE at c=9, and the next grant at c=10.
// -----------------------------------------------------------------------------
module tb_stretched_pulse_tx_arbiter;

    logic       wr_clk;
    logic       wr_resetn;
    logic [3:0] req_pulse;
    logic       clr_err;
    logic       tx_pulse;
    logic [1:0] tx_id;
    logic [3:0] ack;
    logic [3:0] pending;
    logic       busy;
    logic [3:0] drop_err;

    int checks;
    int failures;

    stretched_pulse_tx_arbiter #(
        .NREQ   (4),
        .ID_W   (2),
        .STRETCH(4),
        .GAP    (4)
    ) dut (
        .wr_clk   (wr_clk),
        .wr_resetn(wr_resetn),
        .req_pulse(req_pulse),
        .clr_err  (clr_err),
        .tx_pulse (tx_pulse),
        .tx_id    (tx_id),
        .ack      (ack),
        .pending  (pending),
        .busy     (busy),
        .drop_err (drop_err)
    );

    initial wr_clk = 1'b0;
    always #5 wr_clk = ~wr_clk;

    task automatic tick();
        @(posedge wr_clk);
        #1;
    endtask

    task automatic do_reset();
        wr_resetn = 1'b0;
        req_pulse = '0;
        clr_err   = 1'b0;
        tick();
        tick();
        wr_resetn = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        wr_resetn = 1'b0;
        req_pulse = '0;
        clr_err   = 1'b0;
        #2;
        checks++; if (tx_pulse !== 1'b0) begin failures++; $display("FAIL reset_tx_pulse got=%0b exp=0", tx_pulse); end
        checks++; if (tx_id !== 2'd0) begin failures++; $display("FAIL reset_tx_id got=%0d exp=0", tx_id); end
        checks++; if (ack !== 4'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0000", ack); end
        checks++; if (pending !== 4'b0) begin failures++; $display("FAIL reset_pending got=%b exp=0000", pending); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (drop_err !== 4'b0) begin failures++; $display("FAIL reset_drop_err got=%b exp=0000", drop_err); end
        tick();
        wr_resetn = 1'b1;
        tick();
        $display("test_reset: outputs at reset values checked");
    endtask

    task automatic test_single();
        logic       exp_tx;
        logic [3:0] exp_ack;
        logic       exp_busy;
        req_pulse = 4'b0001;
        tick();
        req_pulse = 4'b0000;
        checks++; if (pending !== 4'b0001) begin failures++; $display("FAIL single_pending_c0 got=%b exp=0001", pending); end
        checks++; if (tx_pulse !== 1'b0) begin failures++; $display("FAIL single_tx_c0 got=%0b exp=0", tx_pulse); end
        for (int c = 1; c <= 10; c++) begin
            tick();
            exp_tx   = (c >= 1 && c <= 4);
            exp_ack  = (c == 4) ? 4'b0001 : 4'b0000;
            exp_busy = (c <= 8);
            checks++; if (tx_pulse !== exp_tx) begin failures++; $display("FAIL single_tx c=%0d got=%0b exp=%0b", c, tx_pulse, exp_tx); end
            checks++; if (ack !== exp_ack) begin failures++; $display("FAIL single_ack c=%0d got=%b exp=%b", c, ack, exp_ack); end
            checks++; if (busy !== exp_busy) begin failures++; $display("FAIL single_busy c=%0d got=%0b exp=%0b", c, busy, exp_busy); end
            checks++; if (tx_id !== 2'd0) begin failures++; $display("FAIL single_tx_id c=%0d got=%0d exp=0", c, tx_id); end
            checks++; if (pending !== 4'b0) begin failures++; $display("FAIL single_pending c=%0d got=%b exp=0000", c, pending); end
        end
        $display("test_single: one event id 0, 4-cycle pulse, ack at c=4");
    endtask

    task automatic test_round_robin();
        int         n;
        int         ph;
        logic       exp_tx;
        logic [3:0] exp_ack;
        logic [1:0] exp_id;
        do_reset();
        req_pulse = 4'b1111;
        tick();
        req_pulse = 4'b0000;
        checks++; if (pending !== 4'b1111) begin failures++; $display("FAIL rr_pending_c0 got=%b exp=1111", pending); end
        for (int c = 1; c <= 37; c++) begin
            tick();
            n       = (c - 1) / 9;
            ph      = (c - 1) % 9;
            exp_tx  = (n < 4) && (ph < 4);
            exp_ack = ((n < 4) && (ph == 3)) ? (4'b0001 << n) : 4'b0000;
            exp_id  = 2'(n);
            checks++; if (tx_pulse !== exp_tx) begin failures++; $display("FAIL rr_tx c=%0d got=%0b exp=%0b", c, tx_pulse, exp_tx); end
            checks++; if (ack !== exp_ack) begin failures++; $display("FAIL rr_ack c=%0d got=%b exp=%b", c, ack, exp_ack); end
            if (exp_tx) begin
                checks++; if (tx_id !== exp_id) begin failures++; $display("FAIL rr_tx_id c=%0d got=%0d exp=%0d", c, tx_id, exp_id); end
            end
        end
        $display("test_round_robin: ids 0,1,2,3 with 5-cycle low gaps");
    endtask

    task automatic test_wrap();
        do_reset();
        req_pulse = 4'b0100;
        tick();
        req_pulse = 4'b0101;
        tick();
        req_pulse = 4'b0000;
        checks++; if (tx_id !== 2'd2) begin failures++; $display("FAIL wrap_first_id got=%0d exp=2", tx_id); end
        for (int c = 2; c <= 20; c++) begin
            tick();
            if (c == 2) begin
                checks++; if (pending !== 4'b0101) begin failures++; $display("FAIL wrap_pending got=%b exp=0101", pending); end
            end
            if (c == 9) begin
                checks++; if (busy !== 1'b0) begin failures++; $display("FAIL wrap_idle_busy got=%0b exp=0", busy); end
            end
            if (c == 10) begin
                checks++; if (tx_pulse !== 1'b1) begin failures++; $display("FAIL wrap_tx2 got=%0b exp=1", tx_pulse); end
                checks++; if (tx_id !== 2'd0) begin failures++; $display("FAIL wrap_second_id got=%0d exp=0", tx_id); end
            end
            if (c == 19) begin
                checks++; if (tx_pulse !== 1'b1) begin failures++; $display("FAIL wrap_tx3 got=%0b exp=1", tx_pulse); end
                checks++; if (tx_id !== 2'd2) begin failures++; $display("FAIL wrap_third_id got=%0d exp=2", tx_id); end
            end
        end
        $display("test_wrap: after id 2, pending 0101 served as 0 then 2");
    endtask

    task automatic test_merge_err();
        logic prev_tx;
        int   rises;
        do_reset();
        req_pulse = 4'b1000;
        tick();
        req_pulse = 4'b0000;
        tick();
        req_pulse = 4'b0010;
        tick();
        req_pulse = 4'b0000;
        checks++; if (drop_err !== 4'b0000) begin failures++; $display("FAIL merge_no_err_yet got=%b exp=0000", drop_err); end
        tick();
        req_pulse = 4'b0010;
        tick();
        req_pulse = 4'b0000;
        checks++; if (drop_err !== 4'b0010) begin failures++; $display("FAIL merge_drop_err got=%b exp=0010", drop_err); end
        checks++; if (pending !== 4'b0010) begin failures++; $display("FAIL merge_pending got=%b exp=0010", pending); end
        prev_tx = tx_pulse;
        rises   = 0;
        for (int c = 5; c <= 25; c++) begin
            tick();
            if (tx_pulse && !prev_tx) rises++;
            prev_tx = tx_pulse;
            if (c == 10) begin
                checks++; if (tx_id !== 2'd1) begin failures++; $display("FAIL merge_id got=%0d exp=1", tx_id); end
            end
        end
        checks++; if (rises !== 1) begin failures++; $display("FAIL merge_pulse_count got=%0d exp=1", rises); end
        checks++; if (drop_err !== 4'b0010) begin failures++; $display("FAIL merge_sticky got=%b exp=0010", drop_err); end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        checks++; if (drop_err !== 4'b0000) begin failures++; $display("FAIL merge_clr got=%b exp=0000", drop_err); end
        $display("test_merge_err: two events on id 1 merged, drop_err set then cleared");
    endtask

    task automatic test_set_over_clear();
        do_reset();
        req_pulse = 4'b0100;
        tick();
        tick();
        req_pulse = 4'b0000;
        checks++; if (tx_pulse !== 1'b1) begin failures++; $display("FAIL soc_tx1 got=%0b exp=1", tx_pulse); end
        checks++; if (tx_id !== 2'd2) begin failures++; $display("FAIL soc_id1 got=%0d exp=2", tx_id); end
        checks++; if (pending !== 4'b0100) begin failures++; $display("FAIL soc_pending got=%b exp=0100", pending); end
        checks++; if (drop_err !== 4'b0000) begin failures++; $display("FAIL soc_no_err got=%b exp=0000", drop_err); end
        for (int c = 2; c <= 14; c++) begin
            tick();
            if (c == 9) begin
                checks++; if (tx_pulse !== 1'b0) begin failures++; $display("FAIL soc_gap got=%0b exp=0", tx_pulse); end
            end
            if (c == 10) begin
                checks++; if (tx_pulse !== 1'b1) begin failures++; $display("FAIL soc_tx2 got=%0b exp=1", tx_pulse); end
                checks++; if (tx_id !== 2'd2) begin failures++; $display("FAIL soc_id2 got=%0d exp=2", tx_id); end
            end
            if (c == 13) begin
                checks++; if (ack !== 4'b0100) begin failures++; $display("FAIL soc_ack2 got=%b exp=0100", ack); end
            end
        end
        checks++; if (pending !== 4'b0000) begin failures++; $display("FAIL soc_pending_end got=%b exp=0000", pending); end
        checks++; if (drop_err !== 4'b0000) begin failures++; $display("FAIL soc_err_end got=%b exp=0000", drop_err); end
        $display("test_set_over_clear: re-armed id 2 sent twice, no drop_err");
    endtask

    task automatic test_reset_mid_send();
        do_reset();
        req_pulse = 4'b0010;
        tick();
        req_pulse = 4'b0001;
        tick();
        req_pulse = 4'b0000;
        tick();
        checks++; if (tx_pulse !== 1'b1) begin failures++; $display("FAIL rst_mid_pre_tx got=%0b exp=1", tx_pulse); end
        wr_resetn = 1'b0;
        #1;
        checks++; if (tx_pulse !== 1'b0) begin failures++; $display("FAIL rst_mid_tx got=%0b exp=0", tx_pulse); end
        checks++; if (tx_id !== 2'd0) begin failures++; $display("FAIL rst_mid_id got=%0d exp=0", tx_id); end
        checks++; if (pending !== 4'b0) begin failures++; $display("FAIL rst_mid_pending got=%b exp=0000", pending); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%0b exp=0", busy); end
        checks++; if (ack !== 4'b0) begin failures++; $display("FAIL rst_mid_ack got=%b exp=0000", ack); end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (ack !== 4'b0 || tx_pulse !== 1'b0) begin failures++; $display("FAIL rst_hold k=%0d ack=%b tx=%0b exp ack=0000 tx=0", k, ack, tx_pulse); end
        end
        wr_resetn = 1'b1;
        tick();
        req_pulse = 4'b0110;
        tick();
        req_pulse = 4'b0000;
        tick();
        checks++; if (tx_pulse !== 1'b1) begin failures++; $display("FAIL rst_after_tx got=%0b exp=1", tx_pulse); end
        checks++; if (tx_id !== 2'd1) begin failures++; $display("FAIL rst_after_id got=%0d exp=1", tx_id); end
        $display("test_reset_mid_send: pulse killed, no ack, search restarts at 0");
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        wr_resetn = 1'b0;
        req_pulse = '0;
        clr_err   = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_merge_err();
        test_set_over_clear();
        test_reset_mid_send();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stretched_pulse_tx_arbiter.md
# stretched_pulse_tx_arbiter

Source-domain scheduler for the shared stretched-pulse CDC channel. It collects single-cycle event pulses from up to NREQ requesters and holds each as a pending bit. It grants one requester at a time in round-robin order, drives the shared line high for exactly STRETCH cycles with the requester ID held alongside, and then enforces a low guard gap so the receive-side synchroniser and edge detector in rd_clk can see every pulse. It sits in the wr_clk domain, directly in front of the CDC crossing.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..16).
- ID_W, 2, width of tx_id. Must satisfy 2^ID_W >= NREQ.
- STRETCH, 4, tx_pulse high time in wr_clk cycles (>=2). Must cover at least 3 rd_clk periods.
- GAP, 4, minimum tx_pulse low time in wr_clk cycles (>=1). Must cover at least 3 rd_clk periods.

Ports:
- wr_clk, in, 1, source-domain clock.
- wr_resetn, in, 1, asynchronous active-low reset.
- req_pulse, in, NREQ, single-cycle event per requester.
- clr_err, in, 1, synchronous clear of drop_err.
- tx_pulse, out, 1, registered stretched pulse to the CDC line.
- tx_id, out, ID_W, registered index of the granted requester. Stable for the whole tx_pulse high window.
- ack, out, NREQ, one-cycle pulse on the granted bit when its stretch completes.
- pending, out, NREQ, requests accepted but not yet granted.
- busy, out, 1, high whenever the FSM is not in IDLE.
- drop_err, out, NREQ, sticky flag: a request was lost.

## Operation
- Pending register:
  - Bit i sets on req_pulse[i].
  - Bit i clears on the cycle requester i is granted.
  - If set and clear occur in the same cycle, set wins and the new event stays pending.
- drop_err:
  - req_pulse[i] while pending[i]=1 and i is not being granted that cycle sets drop_err[i]. The event is merged, not queued.
  - clr_err clears all bits. If clr_err and a new drop occur in the same cycle, the new drop sets the bit.
- FSM states: IDLE, SEND, GAP.
  - IDLE:
    - If pending != 0, grant the first set bit found by searching upward from rr_ptr with wrap-around.
    - On grant: load tx_id, clear that pending bit, set rr_ptr = (id+1) mod NREQ, load cnt = STRETCH-1, go to SEND.
    - If pending = 0, stay in IDLE.
  - SEND:
    - tx_pulse=1.
    - Decrement cnt each cycle.
    - When cnt=0: assert ack[tx_id] for 1 cycle, load cnt = GAP-1, go to GAP.
  - GAP:
    - tx_pulse=0.
    - Decrement cnt each cycle.
    - When cnt=0, go to IDLE.
- tx_pulse is a registered function of the next state, so it is glitch-free. tx_id holds its last value after the pulse ends.
- Counter width is clog2(max(STRETCH,GAP)).
- rr_ptr range is 0..NREQ-1. It wraps from NREQ-1 to 0.

## Timing
- Reset (asynchronous, immediate): state=IDLE, tx_pulse=0, tx_id=0, ack=0, pending=0, busy=0, drop_err=0, rr_ptr=0, cnt=0.
- Reset during SEND drops tx_pulse at once. The in-flight transfer is discarded with no ack.
- Latency: req_pulse sampled at edge k → pending visible after edge k → tx_pulse rises after edge k+1 → tx_pulse high for exactly STRETCH cycles.
- ack is high in the last cycle tx_pulse is high, that is, the cycle in which cnt=0 in SEND.
- Back-to-back grants: tx_pulse low time is GAP+1 cycles (GAP cycles in GAP plus 1 cycle in IDLE). It is never less than GAP+1.
- busy rises with tx_pulse and falls on entry to IDLE.
- Requests arriving during SEND or GAP are held in pending and never lost, except for the same-bit merge case above.

## Test plan
- Single event: reset, req_pulse=4'b0001 for 1 cycle at edge 10 → tx_pulse high edges 12..15 (STRETCH=4), tx_id=0, ack[0] during the cycle ending at edge 16, busy low after GAP+1 cycles, pending=0.
- Round robin: req_pulse=4'b1111 in one cycle → four pulses with tx_id order 0,1,2,3. Each pulse is high 4 cycles; each low gap between pulses is 5 cycles. Four acks in the same order.
- Fairness with wrap: after granting id 2, set pending 4'b0101 → next grant is id 0? No: the search starts at rr_ptr=3, so the order is id 0 then id 2.
- Merge and error: req_pulse[1] twice while pending[1]=1 and id 3 is sending → one pulse for id 1 and drop_err=4'b0010. clr_err then → drop_err=0.
- Set-over-clear: req_pulse[2] on the same cycle id 2 is granted → pending[2] stays 1 → a second pulse with tx_id=2 follows after the gap, and no drop_err.
- Reset mid-SEND: assert wr_resetn=0 during the 2nd high cycle → tx_pulse=0 immediately, all outputs at reset values, no ack. After release the first grant starts from id 0.
